// File: rtl/counter_seq_checker_pkg.sv
// rtl/counter_seq_checker_pkg.sv - shared types and constants for the counter sequence checker
// Contents: FSM state encoding, err_code values, the 0-2-4-5-7-9 lap table, LAP_LEN.
package counter_seq_checker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_ERROR = 2'd3
  } state_t;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_VALUE = 2'b01;
  localparam logic [1:0] ERR_EN    = 2'b10;
  localparam logic [1:0] ERR_HOLD  = 2'b11;

  localparam int LAP_LEN = 6;

  // Entry 0 sits in the low nibble.
  localparam logic [LAP_LEN*4-1:0] SEQ_TABLE = {4'd9, 4'd7, 4'd5, 4'd4, 4'd2, 4'd0};

  function automatic logic [3:0] seq_at(input logic [2:0] idx);
    return (idx < 3'(LAP_LEN)) ? SEQ_TABLE[{idx, 2'b00} +: 4] : 4'd0;
  endfunction

endpackage

// File: rtl/counter_seq_checker_seg7.sv
// rtl/counter_seq_checker_seg7.sv - hex digit to 7-segment decoder (module seg7_decode)
// Ports: value[3:0] in  - nibble to display
//        segments[6:0] out - active-high segments, bit 6 = a ... bit 0 = g
module seg7_decode (
  input  logic [3:0] value,
  output logic [6:0] segments
);

  always_comb begin
    segments = 7'b0000000;
    case (value)
      4'h0: segments = 7'b1111110;
      4'h1: segments = 7'b0110000;
      4'h2: segments = 7'b1101101;
      4'h3: segments = 7'b1111001;
      4'h4: segments = 7'b0110011;
      4'h5: segments = 7'b1011011;
      4'h6: segments = 7'b1011111;
      4'h7: segments = 7'b1110000;
      4'h8: segments = 7'b1111111;
      4'h9: segments = 7'b1111011;
      4'hA: segments = 7'b1110111;
      4'hB: segments = 7'b0011111;
      4'hC: segments = 7'b1001110;
      4'hD: segments = 7'b0111101;
      4'hE: segments = 7'b1001111;
      4'hF: segments = 7'b1000111;
      default: segments = 7'b0000000;
    endcase
  end

endmodule

// File: rtl/counter_seq_checker.sv
// rtl/counter_seq_checker.sv - checks an upstream 0-2-4-5-7-9 counter through run/pause phases
// Optional feature macro: SEQCHK_SEG7_EN (adds registered seg7 display output).
// Ports: clk, reset (sync, active-high)
//        oe_in, en_in, q_in[3:0]  - upstream counter valid, run flag, value
//        expected[3:0]            - value required on the current run cycle
//        lap_cnt[1:0], pause_lap[1:0] - completed run / pause laps in current phase
//        cycle_done               - one-clock pulse per completed run+pause cycle
//        err, err_code[1:0]       - sticky error and its cause
//        seg7[6:0]                - (SEQCHK_SEG7_EN only) display of q_in, "E" on error
module counter_seq_checker
  import counter_seq_checker_pkg::*;
#(
  parameter int RUN_LAPS   = 3,
  parameter int PAUSE_LAPS = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       oe_in,
  input  logic       en_in,
  input  logic [3:0] q_in,
  output logic [3:0] expected,
  output logic [1:0] lap_cnt,
  output logic [1:0] pause_lap,
  output logic       cycle_done,
  output logic       err,
  output logic [1:0] err_code
`ifdef SEQCHK_SEG7_EN
  ,
  output logic [6:0] seg7
`endif
);

  state_t     state_q, state_d;
  logic [2:0] idx_q;
  logic [1:0] lap_q;
  logic [1:0] plap_q;
  logic [2:0] pcnt_q;
  logic [3:0] held_q;
  logic [1:0] code_q;
  logic       done_q;

  logic value_ok, hold_ok, lap_end, run_last, plap_end, pause_last;

  assign value_ok   = (q_in == seq_at(idx_q));
  assign hold_ok    = (q_in == held_q);
  assign lap_end    = (idx_q == 3'(LAP_LEN - 1));
  assign run_last   = lap_end && (lap_q == 2'(RUN_LAPS - 1));
  assign plap_end   = (pcnt_q == 3'(LAP_LEN - 1));
  assign pause_last = plap_end && (plap_q == 2'(PAUSE_LAPS - 1));

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; en_in faults are tested before value faults so they win.
  always_comb begin
    state_d = state_q;
    if (oe_in) begin
      case (state_q)
        ST_IDLE:  if (en_in) state_d = (q_in == 4'd0) ? ST_RUN : ST_ERROR;
        ST_RUN:   if (!en_in || !value_ok) state_d = ST_ERROR;
                  else if (run_last)       state_d = ST_PAUSE;
        ST_PAUSE: if (en_in || !hold_ok)   state_d = ST_ERROR;
                  else if (pause_last)     state_d = ST_RUN;
        default:  state_d = ST_ERROR;
      endcase
    end
  end

  // Counters, held value, error cause and done pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q  <= 3'd0;
      lap_q  <= 2'd0;
      plap_q <= 2'd0;
      pcnt_q <= 3'd0;
      held_q <= 4'd0;
      code_q <= ERR_NONE;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (oe_in) begin
        case (state_q)
          ST_IDLE: begin
            // The q_in=0 start cycle is the first element of lap 0.
            if (en_in) begin
              if (q_in == 4'd0) idx_q  <= 3'd1;
              else              code_q <= ERR_VALUE;
            end
          end
          ST_RUN: begin
            if (!en_in)          code_q <= ERR_EN;
            else if (!value_ok)  code_q <= ERR_VALUE;
            else begin
              idx_q <= lap_end ? 3'd0 : idx_q + 3'd1;
              if (lap_end) begin
                if (run_last) begin
                  lap_q  <= 2'd0;
                  pcnt_q <= 3'd0;
                  plap_q <= 2'd0;
                  held_q <= q_in;
                end else begin
                  lap_q <= lap_q + 2'd1;
                end
              end
            end
          end
          ST_PAUSE: begin
            if (en_in)            code_q <= ERR_EN;
            else if (!hold_ok)    code_q <= ERR_HOLD;
            else if (plap_end) begin
              pcnt_q <= 3'd0;
              if (pause_last) begin
                plap_q <= 2'd0;
                idx_q  <= 3'd0;
                done_q <= 1'b1;
              end else begin
                plap_q <= plap_q + 2'd1;
              end
            end else begin
              pcnt_q <= pcnt_q + 3'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Outputs; ERROR is only left through reset, so err follows the state.
  always_comb begin
    expected   = seq_at(idx_q);
    lap_cnt    = lap_q;
    pause_lap  = plap_q;
    cycle_done = done_q;
    err        = (state_q == ST_ERROR);
    err_code   = code_q;
  end

`ifdef SEQCHK_SEG7_EN
  logic [6:0] seg_dec;

  seg7_decode u_seg7_decode (
    .value    (q_in),
    .segments (seg_dec)
  );

  always_ff @(posedge clk) begin
    if (reset)                    seg7 <= 7'b0000000;
    else if (!oe_in)              seg7 <= 7'b0000000;
    else if (state_d == ST_ERROR) seg7 <= 7'b1001111;
    else                          seg7 <= seg_dec;
  end
`endif

endmodule

// File: tb/tb_counter_seq_checker.sv
// tb/tb_counter_seq_checker.sv - randomized self-checking bench for counter_seq_checker
module tb_counter_seq_checker;

  localparam int RUN_LAPS   = 3;
  localparam int PAUSE_LAPS = 2;
  localparam int PERIOD     = (RUN_LAPS + PAUSE_LAPS) * 6;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       oe_in = 1'b0;
  logic       en_in = 1'b0;
  logic [3:0] q_in = 4'd0;
  logic [3:0] expected;
  logic [1:0] lap_cnt;
  logic [1:0] pause_lap;
  logic       cycle_done;
  logic       err;
  logic [1:0] err_code;
`ifdef SEQCHK_SEG7_EN
  logic [6:0] seg7;
`endif

  counter_seq_checker #(.RUN_LAPS(RUN_LAPS), .PAUSE_LAPS(PAUSE_LAPS)) dut (
    .clk        (clk),
    .reset      (reset),
    .oe_in      (oe_in),
    .en_in      (en_in),
    .q_in       (q_in),
    .expected   (expected),
    .lap_cnt    (lap_cnt),
    .pause_lap  (pause_lap),
    .cycle_done (cycle_done),
    .err        (err),
    .err_code   (err_code)
`ifdef SEQCHK_SEG7_EN
    ,
    .seg7       (seg7)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int seqv[6] = '{0, 2, 4, 5, 7, 9};

  // Reference model: phase 0 idle, 1 run, 2 pause, 3 error.
  // m_rc = correct run values seen in this run phase, m_pc = good pause cycles.
  int m_ph = 0, m_rc = 0, m_pc = 0, m_code = 0;
  bit m_done = 0;
  int t = 0;  // position of the ideal upstream counter within its period

  logic [13:0] dut_vec;
  assign dut_vec = {expected, lap_cnt, pause_lap, cycle_done, err, err_code};

  function automatic logic [13:0] model_vec();
    return {4'(seqv[m_rc % 6]), 2'(m_rc / 6), 2'(m_pc / 6), m_done, (m_ph == 3), 2'(m_code)};
  endfunction

  task automatic model_update(input logic r, input logic o, input logic e, input logic [3:0] q);
    m_done = 0;
    if (r) begin
      m_ph = 0; m_rc = 0; m_pc = 0; m_code = 0;
    end else if (o) begin
      case (m_ph)
        0: if (e) begin
             if (q == 0) begin m_ph = 1; m_rc = 1; end
             else begin m_ph = 3; m_code = 1; end
           end
        1: if (!e) begin m_ph = 3; m_code = 2; end
           else if (int'(q) != seqv[m_rc % 6]) begin m_ph = 3; m_code = 1; end
           else begin
             m_rc++;
             if (m_rc == RUN_LAPS * 6) begin m_rc = 0; m_pc = 0; m_ph = 2; end
           end
        2: if (e) begin m_ph = 3; m_code = 2; end
           else if (q != 4'd9) begin m_ph = 3; m_code = 3; end
           else begin
             m_pc++;
             if (m_pc == PAUSE_LAPS * 6) begin m_pc = 0; m_ph = 1; m_done = 1; end
           end
        default: ;
      endcase
    end
  endtask

  task automatic step(input logic r, input logic o, input logic e, input logic [3:0] q);
    @(negedge clk);
    reset = r; oe_in = o; en_in = e; q_in = q;
    @(posedge clk);
    model_update(r, o, e, q);
    #1;
  endtask

  task automatic ideal_step(input logic o);
    logic e;
    logic [3:0] q;
    e = (t < RUN_LAPS * 6);
    q = e ? 4'(seqv[t % 6]) : 4'd9;
    if (o) step(1'b0, 1'b1, e, q);
    else   step(1'b0, 1'b0, 1'($urandom), 4'($urandom));
    if (o) t = (t + 1) % PERIOD;
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, 4'd0);
    t = 0;
  endtask

  task automatic goto_t(input int target);
    for (int i = 0; i < PERIOD && t != target; i++) ideal_step(1'b1);
  endtask

  task automatic test_reset();
    step(1'b1, 1'b1, 1'b1, 4'd7);
    step(1'b1, 1'b0, 1'b0, 4'd0);
    t = 0;
    n_tests++;
    if (dut_vec !== 14'd0) begin
      n_fail++;
      $display("FAIL reset_state got=%h want=%h", dut_vec, 14'd0);
    end
  endtask

  task automatic test_ideal();
    int dones = 0;
    do_reset();
    for (int i = 0; i < 2 * PERIOD; i++) begin
      ideal_step(1'b1);
      dones += int'(cycle_done);
      n_tests++;
      if (dut_vec !== model_vec()) begin
        n_fail++;
        $display("FAIL ideal i=%0d got=%h want=%h", i, dut_vec, model_vec());
      end
    end
    n_tests++;
    if (dones != 2) begin
      n_fail++;
      $display("FAIL ideal_done_count got=%0d want=2", dones);
    end
  endtask

  task automatic test_oe_gaps();
    do_reset();
    for (int i = 0; i < 150; i++) begin
      ideal_step(1'($urandom_range(0, 3) != 0));
      n_tests++;
      if (dut_vec !== model_vec()) begin
        n_fail++;
        $display("FAIL oe_gap i=%0d got=%h want=%h", i, dut_vec, model_vec());
      end
    end
  endtask

  task automatic test_value_fault();
    do_reset();
    goto_t(9);
    step(1'b0, 1'b1, 1'b1, 4'd6);
    n_tests++;
    if ({err, err_code, expected} !== {1'b1, 2'b01, 4'd5}) begin
      n_fail++;
      $display("FAIL value_fault got=%b/%b/%0d want=1/01/5", err, err_code, expected);
    end
    for (int i = 0; i < 4; i++) begin
      ideal_step(1'b1);
      n_tests++;
      if (dut_vec !== model_vec()) begin
        n_fail++;
        $display("FAIL value_frozen i=%0d got=%h want=%h", i, dut_vec, model_vec());
      end
    end
  endtask

  task automatic test_en_fault();
    do_reset();
    goto_t(6);
    step(1'b0, 1'b1, 1'b0, 4'd0);
    n_tests++;
    if ({err, err_code} !== 3'b110) begin
      n_fail++;
      $display("FAIL en_drop_run got=%b%b want=110", err, err_code);
    end
    do_reset();
    goto_t(RUN_LAPS * 6 + 3);
    step(1'b0, 1'b1, 1'b1, 4'd9);
    n_tests++;
    if ({err, err_code, lap_cnt} !== {3'b110, 2'd0}) begin
      n_fail++;
      $display("FAIL en_high_pause got=%b%b lap=%0d want=110 lap=0", err, err_code, lap_cnt);
    end
  endtask

  task automatic test_hold_fault();
    do_reset();
    goto_t(RUN_LAPS * 6 + 6);
    step(1'b0, 1'b1, 1'b0, 4'd0);
    n_tests++;
    if ({err, err_code, pause_lap} !== {3'b111, 2'd1}) begin
      n_fail++;
      $display("FAIL hold_moved got=%b%b plap=%0d want=111 plap=1", err, err_code, pause_lap);
    end
    do_reset();
    goto_t(RUN_LAPS * 6 + 6);
    step(1'b0, 1'b1, 1'b1, 4'd0);
    n_tests++;
    if ({err, err_code} !== 3'b110) begin
      n_fail++;
      $display("FAIL hold_and_en got=%b%b want=110", err, err_code);
    end
  endtask

  task automatic test_reset_mid_pause();
    int dones = 0;
    do_reset();
    goto_t(RUN_LAPS * 6 + 7);
    step(1'b1, 1'b1, 1'b0, 4'd9);
    t = 0;
    n_tests++;
    if (dut_vec !== 14'd0) begin
      n_fail++;
      $display("FAIL reset_mid_pause got=%h want=%h", dut_vec, 14'd0);
    end
    // Upstream carries on pausing; the checker must sit idle without a done pulse.
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, 1'b0, 4'd9);
      dones += int'(cycle_done);
      n_tests++;
      if (dut_vec !== model_vec()) begin
        n_fail++;
        $display("FAIL after_reset i=%0d got=%h want=%h", i, dut_vec, model_vec());
      end
    end
    n_tests++;
    if (dones != 0) begin
      n_fail++;
      $display("FAIL reset_no_done got=%0d want=0", dones);
    end
  endtask

  task automatic test_random_faults();
    int k;
    for (int trial = 0; trial < 25; trial++) begin
      do_reset();
      k = $urandom_range(0, 2 * PERIOD);
      for (int i = 0; i < k; i++) ideal_step(1'b1);
      step(1'b0, 1'b1, 1'($urandom), 4'($urandom));
      for (int i = 0; i < 4; i++) begin
        n_tests++;
        if (dut_vec !== model_vec()) begin
          n_fail++;
          $display("FAIL random_fault trial=%0d k=%0d i=%0d got=%h want=%h", trial, k, i, dut_vec, model_vec());
        end
        ideal_step(1'($urandom_range(0, 4) != 0));
      end
    end
  endtask

`ifdef SEQCHK_SEG7_EN
  task automatic test_seg7();
    do_reset();
    step(1'b0, 1'b1, 1'b0, 4'd4);
    n_tests++;
    if (seg7 !== 7'b0110011) begin
      n_fail++;
      $display("FAIL seg7_four got=%b want=0110011", seg7);
    end
    step(1'b0, 1'b0, 1'b0, 4'd4);
    n_tests++;
    if (seg7 !== 7'b0000000) begin
      n_fail++;
      $display("FAIL seg7_blank got=%b want=0000000", seg7);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_ideal();
    test_oe_gaps();
    test_value_fault();
    test_en_fault();
    test_hold_fault();
    test_reset_mid_pause();
    test_random_faults();
`ifdef SEQCHK_SEG7_EN
    test_seg7();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/counter_seq_checker.md
COUNTER_SEQ_CHECKER -- requirements
Module: counter_seq_checker

Interface
REQ-001 Parameter RUN_LAPS, default 3, meaning: full 0-2-4-5-7-9 laps per run phase (1..3).
REQ-002 Parameter PAUSE_LAPS, default 2, meaning: pause length in laps, one lap = 6 clocks (1..3).
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 oe_in  input  1  upstream counter output-valid; checking only when high.
REQ-006 en_in  input  1  upstream counter run indicator (1 = counting, 0 = paused).
REQ-007 q_in  input  4  upstream counter value.
REQ-008 expected  output  4  value required from q_in on the current run cycle.
REQ-009 lap_cnt  output  2  completed laps in the current run phase.
REQ-010 pause_lap  output  2  completed pause laps in the current pause phase.
REQ-011 cycle_done  output  1  one-clock pulse when a full run+pause cycle completes.
REQ-012 err  output  1  sticky error flag.
REQ-013 err_code  output  2  00 none, 01 value mismatch, 10 en timing, 11 q moved during pause.

Function
REQ-014 The block shall implement states IDLE, RUN, PAUSE, ERROR.
REQ-015 Cycles with oe_in=0 shall perform no check and freeze all state, counters and outputs.
REQ-016 IDLE: first oe_in=1 and en_in=1 cycle with q_in=0 shall enter RUN; en_in=1 with q_in!=0 shall enter ERROR code 01; en_in=0 shall stay IDLE.
REQ-017 RUN: each valid cycle shall require en_in=1 and q_in==expected; expected then advances 0->2->4->5->7->9->0.
REQ-018 RUN: on a correct q_in=9, lap_cnt shall increment; when it reaches RUN_LAPS the state shall become PAUSE, lap_cnt cleared, pause cycle counter cleared, held value latched as 9.
REQ-019 PAUSE: each valid cycle shall require en_in=0 and q_in equal to the latched value; after PAUSE_LAPS*6 such cycles the state shall return to RUN with expected=0, pause_lap cleared, and cycle_done pulsed for exactly one clock.
REQ-020 pause_lap shall increment every 6 valid pause cycles, wrapping to 0 at phase exit.
REQ-021 en_in=0 in RUN, or en_in=1 in PAUSE, shall enter ERROR with code 10.
REQ-022 q_in mismatch in RUN shall give code 01; q_in change in PAUSE shall give code 11.
REQ-023 Simultaneous en_in and value faults in one cycle shall report code 10 (en timing has priority).
REQ-024 ERROR shall hold err=1, err_code, expected, lap_cnt, pause_lap frozen until reset; cycle_done=0.
REQ-025 Check-to-flag latency shall be one clock: err asserts on the edge after the faulty cycle is sampled.

Reset
REQ-026 reset=1 at a clock edge shall force IDLE, expected=0, lap_cnt=0, pause_lap=0, cycle_done=0, err=0, err_code=00, regardless of current state.
REQ-027 reset asserted mid-lap or mid-pause shall discard all progress; no cycle_done shall be emitted.

Configuration
REQ-028 Macro SEQCHK_SEG7_EN defined: the block shall add output seg7 (7 bits, active-high segments a..g) registered from q_in decode, blank (all 0) when oe_in=0, showing "E" in ERROR.
REQ-029 Macro SEQCHK_SEG7_EN undefined: no seg7 port and no decode logic shall exist.

Structure
REQ-030 A shared package shall hold the state encoding, err_code constants, the 6-entry sequence table (0,2,4,5,7,9) and LAP_LEN=6.
REQ-031 The 7-segment decode shall be a sub-module seg7_decode, instantiated only under SEQCHK_SEG7_EN.

Verification
REQ-032 Reset, then ideal counter stream (3 laps, 12 paused clocks holding 9, repeat) -> err=0 throughout, cycle_done pulse every 30 clocks, lap_cnt 0..2, pause_lap 0..1.
REQ-033 Run lap 2, inject q_in=6 instead of 5 -> next edge err=1, err_code=01, expected frozen at 5.
REQ-034 Drop en_in to 0 after lap 1 -> err_code=10; separately keep en_in=1 in pause clock 4 -> err_code=10.
REQ-035 Pause with q_in stepping 9->0 at pause clock 7 -> err_code=11; same clock also en_in=1 -> err_code=10.
REQ-036 oe_in=0 for 5 clocks mid-run with garbage q_in -> no error, expected unchanged; assert reset mid-pause -> all outputs zero, IDLE, no cycle_done.
REQ-037 With SEQCHK_SEG7_EN, q_in=4 and oe_in=1 -> seg7=7'b0110011 one clock later; oe_in=0 -> seg7=0.
